// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop input synchronizer, mid-bit sampling state machine,
// and a sticky ready flag that holds the last good byte until the next confirmed start.
module uart_rx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_line,
    output logic       ready,
    output logic [7:0] data,
    output logic       frame_error
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int HALF  = CLK_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             ready_q, ready_d;
    logic [7:0]       data_q, data_d;
    logic             ferr_q, ferr_d;
    logic             rx;

    assign rx = sync2_q;

    always_comb begin
        sync1_d = serial_line;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ready_d = ready_q;
        data_d  = data_q;
        ferr_d  = ferr_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            // Half a bit into the start bit: a line still low is a real start, otherwise a glitch.
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx) begin
                        ready_d = 1'b0;
                        ferr_d  = 1'b0;
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Returning to IDLE at mid stop bit leaves half a bit to catch a back-to-back start.
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        ferr_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_BREAK: begin
                if (rx) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            ready_q <= 1'b0;
            data_q  <= 8'h00;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
        end
    end

    assign ready       = ready_q;
    assign data        = data_q;
    assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, outputs compared every cycle
// against a frame-level expectation of ready/data/frame_error.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_line;
    logic       ready;
    logic [7:0] data;
    logic       frame_error;

    int checks = 0;
    int errors = 0;

    // Frame-level model: what the outputs must show outside the short windows
    // around a mid-start or mid-stop decision.
    logic       exp_ready;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       blank;

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_line (serial_line),
        .ready       (ready),
        .data        (data),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance n clocks; every negedge in between compares the DUT against the model.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!blank) begin
                checks++;
                if (ready !== exp_ready || data !== exp_data || frame_error !== exp_ferr) begin
                    errors++;
                    $display("FAIL model t=%0t ready=%b data=%h ferr=%b required ready=%b data=%h ferr=%b",
                             $time, ready, data, frame_error, exp_ready, exp_data, exp_ferr);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_bit(input logic probe);
        serial_line = 1'b0;
        tick(HALF - 4);
        blank = 1'b1;
        tick(3);
        if (probe) chk("ready_before_mid_start", 8'(ready), 8'h01);
        tick(6);
        if (probe) chk("ready_after_mid_start", 8'(ready), 8'h00);
        tick(CPB - HALF - 5);
        exp_ready = 1'b0;
        exp_ferr  = 1'b0;
        blank     = 1'b0;
    endtask

    task automatic data_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            serial_line = b[i];
            tick(CPB);
        end
    endtask

    task automatic stop_bit(input logic [7:0] b, input logic stop_val);
        serial_line = stop_val;
        tick(HALF - 4);
        blank = 1'b1;
        tick(CPB - HALF + 4);
        if (stop_val) begin
            exp_ready = 1'b1;
            exp_data  = b;
        end else begin
            exp_ready = 1'b0;
        end
        exp_ferr    = ~stop_val;
        blank       = 1'b0;
        serial_line = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic probe);
        start_bit(probe);
        data_bits(b, 8);
        stop_bit(b, stop_val);
    endtask

    task automatic glitch(input int len);
        serial_line = 1'b0;
        tick(len);
        serial_line = 1'b1;
        tick(CPB);
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        int         gap;

        rst         = 1'b1;
        serial_line = 1'b1;
        blank       = 1'b1;
        exp_ready   = 1'b0;
        exp_data    = 8'h00;
        exp_ferr    = 1'b0;
        tick(3);
        chk("reset_ready", 8'(ready), 8'h00);
        chk("reset_data", data, 8'h00);
        chk("reset_ferr", 8'(frame_error), 8'h00);
        rst = 1'b0;
        tick(2);
        blank = 1'b0;
        tick(CPB);

        // Every byte value, one idle bit after each frame.
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, 1'b0);
            tick(CPB);
            chk("sweep_ready", 8'(ready), 8'h01);
            chk("sweep_data", data, b);
            chk("sweep_ferr", 8'(frame_error), 8'h00);
        end

        // Sticky ready across a long idle, then cleared at the next mid-start.
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(1000);
        chk("sticky_ready", 8'(ready), 8'h01);
        chk("sticky_data", data, 8'hA5);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(CPB);
        chk("after_sticky_data", data, 8'h5A);

        // Short low glitch on an idle line.
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(CPB);
        glitch(HALF - 2);
        tick(CPB);
        chk("glitch_ready", 8'(ready), 8'h01);
        chk("glitch_data", data, 8'h3C);
        send_frame(8'h81, 1'b1, 1'b0);
        tick(CPB);
        chk("post_glitch_data", data, 8'h81);

        // Low stop bit.
        send_frame(8'h55, 1'b0, 1'b0);
        chk("ferr_set", 8'(frame_error), 8'h01);
        chk("ferr_ready", 8'(ready), 8'h00);
        chk("ferr_data_kept", data, 8'h81);
        tick(2 * CPB);
        send_frame(8'h12, 1'b1, 1'b0);
        tick(CPB);
        chk("post_ferr_data", data, 8'h12);
        chk("post_ferr_ready", 8'(ready), 8'h01);
        chk("post_ferr_ferr", 8'(frame_error), 8'h00);

        // Reset during data bit 4.
        b = 8'h6B;
        start_bit(1'b0);
        data_bits(b, 4);
        serial_line = b[4];
        tick(HALF);
        rst         = 1'b1;
        serial_line = 1'b1;
        exp_ready   = 1'b0;
        exp_data    = 8'h00;
        exp_ferr    = 1'b0;
        #1;
        chk("midreset_ready", 8'(ready), 8'h00);
        chk("midreset_data", data, 8'h00);
        tick(3);
        rst = 1'b0;
        tick(2 * CPB);
        send_frame(8'hC3, 1'b1, 1'b0);
        tick(CPB);
        chk("post_reset_data", data, 8'hC3);
        chk("post_reset_ready", 8'(ready), 8'h01);

        // Back-to-back frames with no idle gap.
        send_frame(8'h01, 1'b1, 1'b0);
        chk("b2b_first", data, 8'h01);
        send_frame(8'hFE, 1'b1, 1'b0);
        chk("b2b_second", data, 8'hFE);
        chk("b2b_ready", 8'(ready), 8'h01);
        tick(CPB);

        // Random frames, stop-bit errors, gaps and glitches.
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 3) == 0) begin
                glitch(int'($urandom_range(1, HALF - 2)));
            end
            send_frame(b, ok, 1'b0);
            gap = ok ? int'($urandom_range(0, 2 * CPB)) : int'($urandom_range(CPB, 3 * CPB));
            tick(gap);
        end
        tick(CPB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
